// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with req/ack data-memory handshake and MEM2WB register.
// Holds the upstream pipe while an access is outstanding; non-memory ops pass in one cycle.
module mem_access_stage #(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_EN_IN,
    input  logic                  MEM_R_EN_IN,
    input  logic                  MEM_W_EN_IN,
    input  logic                  MUL_EN_IN,
    input  logic                  COMP_EN_IN,
    input  logic [WORD_W-1:0]     ALUResIn,
    input  logic [WORD_W-1:0]     STValIn,
    input  logic [WORD_W-1:0]     HIGH_IN,
    input  logic [REG_ADDR_W-1:0] destIn,
    output logic                  freeze,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  WB_EN,
    output logic                  MEM_R_EN,
    output logic                  MUL_EN_OUT,
    output logic                  COMP_EN_OUT,
    output logic [WORD_W-1:0]     ALURes,
    output logic [WORD_W-1:0]     MemData,
    output logic [WORD_W-1:0]     HIGH_OUT,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  err_timeout,
    output logic                  err_misalign
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            timer_q, timer_d;
    logic [WORD_W-1:0]     data_q, data_d;
    logic                  req_q, req_d, we_q, we_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  err_to_q, err_to_d, err_mis_q, err_mis_d;
    logic                  wb_q, wb_d, mr_q, mr_d, mul_q, mul_d, comp_q, comp_d;
    logic [WORD_W-1:0]     alu_q, alu_d, md_q, md_d, hi_q, hi_d;
    logic [REG_ADDR_W-1:0] dst_q, dst_d;
    logic                  mem_op, load_out;

    assign mem_op   = MEM_R_EN_IN | MEM_W_EN_IN;
    assign freeze   = (state_q == IDLE && mem_op) || state_q == WAIT;
    // The WB register takes the current instruction only when it is not being held.
    assign load_out = (state_q == IDLE && !mem_op) || state_q == DONE;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        data_d    = data_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_to_d  = err_to_q;
        err_mis_d = err_mis_q;
        case (state_q)
            IDLE: if (mem_op) begin
                state_d   = WAIT;
                req_d     = 1'b1;
                we_d      = MEM_W_EN_IN;
                addr_d    = ALUResIn[MEM_ADDR_W+1:2];
                wdata_d   = STValIn;
                timer_d   = '0;
                err_mis_d = err_mis_q | (ALUResIn[1:0] != 2'b00);
            end
            WAIT: begin
                timer_d = timer_q + 8'd1;
                if (mem_ack) begin
                    req_d   = 1'b0;
                    data_d  = we_q ? '0 : mem_rdata;
                    state_d = DONE;
                end else if (timer_q == TMAX) begin
                    req_d    = 1'b0;
                    data_d   = '0;
                    err_to_d = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        wb_d   = load_out & WB_EN_IN;
        mr_d   = load_out & MEM_R_EN_IN & ~MEM_W_EN_IN;
        mul_d  = load_out & MUL_EN_IN;
        comp_d = load_out & COMP_EN_IN;
        alu_d  = load_out ? ALUResIn : '0;
        hi_d   = load_out ? HIGH_IN : '0;
        dst_d  = load_out ? destIn : '0;
        md_d   = state_q == DONE ? data_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            data_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_to_q  <= 1'b0;
            err_mis_q <= 1'b0;
            wb_q      <= 1'b0;
            mr_q      <= 1'b0;
            mul_q     <= 1'b0;
            comp_q    <= 1'b0;
            alu_q     <= '0;
            md_q      <= '0;
            hi_q      <= '0;
            dst_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_to_q  <= err_to_d;
            err_mis_q <= err_mis_d;
            wb_q      <= wb_d;
            mr_q      <= mr_d;
            mul_q     <= mul_d;
            comp_q    <= comp_d;
            alu_q     <= alu_d;
            md_q      <= md_d;
            hi_q      <= hi_d;
            dst_q     <= dst_d;
        end
    end

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign WB_EN        = wb_q;
    assign MEM_R_EN     = mr_q;
    assign MUL_EN_OUT   = mul_q;
    assign COMP_EN_OUT  = comp_q;
    assign ALURes       = alu_q;
    assign MemData      = md_q;
    assign HIGH_OUT     = hi_q;
    assign dest         = dst_q;
    assign err_timeout  = err_to_q;
    assign err_misalign = err_mis_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench with a behavioural memory responder.
module tb_mem_access_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        wb_in = 0, mr_in = 0, mw_in = 0, mul_in = 0, comp_in = 0;
    logic [31:0] alu_in = 0, st_in = 0, hi_in = 0, mem_rdata = 0;
    logic [4:0]  dst_in = 0;
    logic        mem_ack = 0;
    logic        freeze, mem_req, mem_we, WB_EN, MEM_R_EN, MUL_EN_OUT, COMP_EN_OUT;
    logic        err_timeout, err_misalign;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, ALURes, MemData, HIGH_OUT;
    logic [4:0]  dest;

    mem_access_stage #(.WORD_W(32), .REG_ADDR_W(5), .MEM_ADDR_W(10), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .WB_EN_IN(wb_in), .MEM_R_EN_IN(mr_in), .MEM_W_EN_IN(mw_in),
        .MUL_EN_IN(mul_in), .COMP_EN_IN(comp_in), .ALUResIn(alu_in), .STValIn(st_in),
        .HIGH_IN(hi_in), .destIn(dst_in), .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MUL_EN_OUT(MUL_EN_OUT), .COMP_EN_OUT(COMP_EN_OUT),
        .ALURes(ALURes), .MemData(MemData), .HIGH_OUT(HIGH_OUT), .dest(dest),
        .err_timeout(err_timeout), .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic wb, mr, mul, comp;
        logic [31:0] alu, md, hi;
        logic [4:0] dst;
    } exp_t;

    exp_t q[$];
    int passed = 0, total = 0, wb_pulses = 0;
    logic tb_valid = 0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    // Memory model: acks on the ack_delay-th cycle of a request, records what it saw.
    int ack_delay = 0, k = 0, last_k = 0;
    bit no_ack = 0, acked = 0;
    logic [31:0] rd_val = 0, cap_wdata = 0;
    logic [9:0]  cap_addr = 0;
    logic        cap_we = 0;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req && !rst) begin
            if (k == 0) begin
                cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
            end
            if (!no_ack && !acked && k == ack_delay) begin
                mem_ack = 1'b1; mem_rdata = rd_val; acked = 1;
            end
            k++;
        end else begin
            if (k > 0) last_k = k;
            k = 0; acked = 0;
        end
    end

    initial begin : monitor
        logic take;
        exp_t act, e;
        forever begin
            @(negedge clk); #2;
            take = tb_valid && !freeze;
            @(posedge clk); #1;
            if (WB_EN) wb_pulses++;
            act = '{WB_EN, MEM_R_EN, MUL_EN_OUT, COMP_EN_OUT, ALURes, MemData, HIGH_OUT, dest};
            if (take) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL sb_underflow: got %h expected none", act);
                end else begin
                    e = q.pop_front();
                    chk("wb_reg", act, e);
                end
            end else chk("bubble", {WB_EN, MEM_R_EN, MUL_EN_OUT, COMP_EN_OUT}, 4'b0);
        end
    end

    task automatic issue(input logic wb, mr, mw, mul, comp, input logic [31:0] alu, st, hi,
                         input logic [4:0] dst, input logic [31:0] md, output int fc);
        @(negedge clk);
        wb_in = wb; mr_in = mr; mw_in = mw; mul_in = mul; comp_in = comp;
        alu_in = alu; st_in = st; hi_in = hi; dst_in = dst; tb_valid = 1;
        q.push_back('{wb, mr & ~mw, mul, comp, alu, md, hi, dst});
        #1; fc = 0;
        while (freeze && fc < 300) begin
            fc++;
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        tb_valid = 0;
        {wb_in, mr_in, mw_in, mul_in, comp_in} = '0;
        alu_in = 0; st_in = 0; hi_in = 0; dst_in = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int fc, w0;
        repeat (2) @(posedge clk); #1;
        chk("rst_outs", {WB_EN, MEM_R_EN, MUL_EN_OUT, COMP_EN_OUT, ALURes, MemData, HIGH_OUT, dest}, 0);
        chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, freeze}, 0);
        chk("rst_err", {err_timeout, err_misalign}, 0);
        @(negedge clk); rst = 0;

        issue(1, 0, 0, 0, 0, 32'h1234, 0, 0, 5, 0, fc);
        chk("alu_freeze", fc, 0);

        ack_delay = 1; rd_val = 32'hDEADBEEF;
        issue(1, 1, 0, 0, 0, 32'h40, 0, 0, 7, 32'hDEADBEEF, fc);
        chk("ld_freeze", fc, 3);
        chk("ld_addr", cap_addr, 10'h10);
        chk("ld_we", cap_we, 0);
        chk("ld_req_cycles", last_k, 2);

        ack_delay = 0;
        issue(1, 0, 1, 0, 0, 32'h8, 32'hA5A5, 0, 3, 0, fc);
        chk("st_freeze", fc, 2);
        chk("st_mem", {cap_we, cap_addr, cap_wdata}, {1'b1, 10'd2, 32'hA5A5});
        chk("st_req_cycles", last_k, 1);

        issue(1, 0, 0, 1, 0, 32'h11, 0, 32'hCAFE, 9, 0, fc);
        chk("mul_freeze", fc, 0);
        issue(1, 0, 0, 0, 1, 32'h1, 0, 0, 2, 0, fc);

        ack_delay = 2; rd_val = 32'h1111;
        repeat (2) @(negedge clk);
        w0 = wb_pulses;
        issue(1, 1, 0, 0, 0, 32'h100, 0, 0, 10, 32'h1111, fc);
        chk("b2b_freeze0", fc, 4);
        rd_val = 32'h2222;
        issue(1, 1, 0, 0, 0, 32'h104, 0, 0, 11, 32'h2222, fc);
        chk("b2b_freeze1", fc, 4);
        chk("b2b_addr1", cap_addr, 10'h41);
        repeat (3) @(negedge clk);
        chk("b2b_wb_pulses", wb_pulses - w0, 2);

        no_ack = 1;
        issue(1, 1, 0, 0, 0, 32'h80, 0, 0, 4, 0, fc);
        chk("to_freeze", fc, 5);
        chk("to_req_cycles", last_k, 4);
        chk("to_err", err_timeout, 1);
        no_ack = 0;

        issue(1, 0, 0, 0, 0, 32'h55, 0, 0, 6, 0, fc);
        chk("post_to_freeze", fc, 0);
        chk("err_sticky", {err_timeout, err_misalign}, 2'b10);

        no_ack = 1;
        @(negedge clk);
        wb_in = 1; mr_in = 1; alu_in = 32'h41; dst_in = 8;
        #1 chk("mis_freeze", freeze, 1);
        @(posedge clk); #1;
        chk("mis_req", {mem_req, mem_addr, err_misalign}, {1'b1, 10'h10, 1'b1});
        @(negedge clk); #3;
        rst = 1;
        #1 chk("rst_wait_req", mem_req, 0);
        chk("rst_wait_err", {err_timeout, err_misalign}, 0);
        wb_in = 0; mr_in = 0; alu_in = 0; dst_in = 0;
        #1 chk("rst_wait_idle", freeze, 0);
        @(negedge clk); rst = 0; no_ack = 0;
        repeat (2) @(negedge clk);
        chk("post_rst_req", mem_req, 0);

        issue(1, 0, 0, 0, 0, 32'h77, 0, 0, 1, 0, fc);
        chk("post_rst_freeze", fc, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
